// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array sequencer.
// Imported by the skew-line block and the sequencer top.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN
    } state_e;

    typedef enum logic {
        SKEW,
        DESKEW
    } skew_mode_e;

    localparam int DIM_DEFAULT = 8;

    function automatic int run_cycles(input int dim);
        return 3 * dim - 1;
    endfunction

    function automatic int lat(input int dim);
        return 2 * dim - 1;
    endfunction

endpackage

// File: rtl/systolic_sequencer_skew_lines.sv
// Per-lane delay lines: SKEW delays lane j by j cycles,
// DESKEW delays lane j by DIM-1-j cycles.
module skew_lines
    import systolic_pkg::*;
#(
    parameter int         DIM  = DIM_DEFAULT,
    parameter skew_mode_e MODE = SKEW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_en,
    input  logic           i_clr,
    input  logic [DIM-1:0] i_d,
    output logic [DIM-1:0] o_q
);

    for (genvar j = 0; j < DIM; j++) begin : g_lane
        localparam int D = (MODE == SKEW) ? j : DIM - 1 - j;

        if (D == 0) begin : g_wire
            assign o_q[j] = i_d[j];
        end else if (D == 1) begin : g_one
            logic r_q;

            // single-stage lane, advances only when enabled
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= 1'b0;
                end else if (i_clr) begin
                    r_q <= 1'b0;
                end else if (i_en) begin
                    r_q <= i_d[j];
                end
            end

            assign o_q[j] = r_q;
        end else begin : g_multi
            logic [D-1:0] r_sh;

            // multi-stage shift lane, advances only when enabled
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sh <= '0;
                end else if (i_clr) begin
                    r_sh <= '0;
                end else if (i_en) begin
                    r_sh <= {r_sh[D-2:0], i_d[j]};
                end
            end

            assign o_q[j] = r_sh[D-1];
        end
    end

endmodule

// File: rtl/systolic_sequencer.sv
// Load/run/drain controller for a DIM x DIM systolic shift array:
// buffers operands, feeds a skewed wavefront, de-skews and streams results.
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int DIM = DIM_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [DIM-1:0] in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [DIM-1:0] arr_in,
    output logic           arr_en,
    input  logic [DIM-1:0] arr_out,
    output logic [DIM-1:0] out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy,
    output logic           done
);

    localparam int RUN_CYCLES = run_cycles(DIM);
    localparam int LAT        = lat(DIM);
    localparam int IW         = $clog2(DIM);
    localparam int TW         = $clog2(RUN_CYCLES);

    localparam logic [IW-1:0] I_LAST = IW'(DIM - 1);
    localparam logic [TW-1:0] T_LAST = TW'(RUN_CYCLES - 1);
    localparam logic [TW-1:0] T_DIM  = TW'(DIM);
    localparam logic [TW-1:0] T_LAT  = TW'(LAT);

    state_e         r_state;
    logic [IW-1:0]  r_idx;
    logic [TW-1:0]  r_t;
    logic           r_in_ready;
    logic           r_arr_en;
    logic           r_out_valid;
    logic           r_busy;
    logic           r_done;
    logic [DIM-1:0] r_ops [DIM];
    logic [DIM-1:0] r_res [DIM];

    logic           w_in_hs;
    logic           w_out_hs;
    logic [DIM-1:0] w_skew_in;
    logic [DIM-1:0] w_skew_out;
    logic [DIM-1:0] w_deskew;

    assign w_in_hs   = r_in_ready & in_valid;
    assign w_out_hs  = r_out_valid & out_ready;
    assign w_skew_in = (r_arr_en && r_t < T_DIM) ? r_ops[r_t[IW-1:0]] : '0;

    skew_lines #(
        .DIM  (DIM),
        .MODE (SKEW)
    ) u_skew (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (r_arr_en),
        .i_clr (abort),
        .i_d   (w_skew_in),
        .o_q   (w_skew_out)
    );

    skew_lines #(
        .DIM  (DIM),
        .MODE (DESKEW)
    ) u_deskew (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (r_arr_en),
        .i_clr (abort),
        .i_d   (arr_out),
        .o_q   (w_deskew)
    );

    // sequencing FSM with registered handshake and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_t         <= '0;
            r_in_ready  <= 1'b0;
            r_arr_en    <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state     <= IDLE;
                r_idx       <= '0;
                r_t         <= '0;
                r_in_ready  <= 1'b0;
                r_arr_en    <= 1'b0;
                r_out_valid <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_state    <= LOAD;
                            r_idx      <= '0;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (w_in_hs) begin
                            if (r_idx == I_LAST) begin
                                r_state    <= RUN;
                                r_idx      <= '0;
                                r_t        <= '0;
                                r_in_ready <= 1'b0;
                                r_arr_en   <= 1'b1;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (r_t == T_LAST) begin
                            r_state     <= DRAIN;
                            r_t         <= '0;
                            r_idx       <= '0;
                            r_arr_en    <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_t <= r_t + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (w_out_hs) begin
                            if (r_idx == I_LAST) begin
                                r_state     <= IDLE;
                                r_idx       <= '0;
                                r_out_valid <= 1'b0;
                                r_busy      <= 1'b0;
                                r_done      <= 1'b1;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // operand capture during LOAD, result capture late in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DIM; k++) begin
                r_ops[k] <= '0;
                r_res[k] <= '0;
            end
        end else if (abort) begin
            for (int k = 0; k < DIM; k++) begin
                r_ops[k] <= '0;
                r_res[k] <= '0;
            end
        end else begin
            if (w_in_hs) begin
                r_ops[r_idx] <= in_data;
            end
            if (r_arr_en && r_t >= T_LAT) begin
                r_res[IW'(r_t - T_LAT)] <= w_deskew;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign arr_en    = r_arr_en;
    assign arr_in    = r_arr_en ? w_skew_out : '0;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_valid ? r_res[r_idx] : '0;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer driving an identity shift array,
// with a timestamp model and directed job scenarios.
module tb_systolic_sequencer;

    localparam int DIM = 8;
    localparam int RUN = 3 * DIM - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] arr_in;
    logic       arr_en;
    logic [7:0] arr_out;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    systolic_sequencer #(.DIM(DIM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .arr_in    (arr_in),
        .arr_en    (arr_en),
        .arr_out   (arr_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    // identity shift array: DIM rows, each column shifts down when enabled
    logic [7:0] arr_row [DIM];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIM; i++) arr_row[i] <= 8'h00;
        end else if (arr_en) begin
            for (int i = DIM - 1; i > 0; i--) arr_row[i] <= arr_row[i-1];
            arr_row[0] <= arr_in;
        end
    end
    assign arr_out = arr_row[DIM-1];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // model: job progress as counts and timestamps
    int         cyc = 0;
    bit         m_act = 1'b0;
    int         m_nin = 0;
    int         m_nout = 0;
    int         m_a = -100;
    int         m_done = -1;
    logic [7:0] m_ops [DIM];

    function automatic bit e_in_ready();
        return m_act && (m_nin < DIM);
    endfunction

    function automatic bit e_arr_en();
        return m_act && (m_nin == DIM) && (cyc >= m_a + 1) && (cyc <= m_a + RUN);
    endfunction

    function automatic bit e_ov();
        return m_act && (m_nin == DIM) && (cyc > m_a + RUN);
    endfunction

    function automatic logic [7:0] e_arr_in();
        logic [7:0] v;
        int tt;
        int src;
        v = 8'h00;
        if (e_arr_en()) begin
            tt = cyc - (m_a + 1);
            for (int j = 0; j < DIM; j++) begin
                src = tt - j;
                if (src >= 0 && src < DIM) v[j] = m_ops[src][j];
            end
        end
        return v;
    endfunction

    always @(posedge clk) begin
        bit rdy;
        bit ov;
        rdy = e_in_ready();
        ov  = e_ov();
        if (!rst_n) begin
            m_act  = 1'b0;
            m_nin  = 0;
            m_nout = 0;
            m_a    = -100;
            m_done = -1;
        end else if (abort) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (start) begin
                m_act  = 1'b1;
                m_nin  = 0;
                m_nout = 0;
                m_a    = -100;
            end
        end else begin
            if (rdy && in_valid) begin
                m_ops[m_nin] = in_data;
                m_nin++;
                if (m_nin == DIM) m_a = cyc;
            end
            if (ov && out_ready) begin
                m_nout++;
                if (m_nout == DIM) begin
                    m_act  = 1'b0;
                    m_done = cyc + 1;
                end
            end
        end
        cyc++;
    end

    logic [7:0] got [$];
    int en_cnt = 0;
    int en_cur = 0;
    int en_max = 0;
    int done_cnt = 0;
    int d_cyc = -1;

    // per-cycle comparison against the model plus job statistics
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", busy, m_act);
            chk("in_ready", in_ready, e_in_ready());
            chk("arr_en", arr_en, e_arr_en());
            chk("arr_in", arr_in, e_arr_in());
            chk("out_valid", out_valid, e_ov());
            chk("done", done, cyc == m_done);
            if (e_ov()) chk("out_data", out_data, m_ops[m_nout]);
            if (arr_en) begin
                en_cnt++;
                en_cur++;
                if (en_cur > en_max) en_max = en_cur;
            end else begin
                en_cur = 0;
            end
            if (out_valid && out_ready) got.push_back(out_data);
            if (done) begin
                done_cnt++;
                d_cyc = cyc;
            end
        end
    end

    logic [7:0] job_ops [DIM];
    logic [7:0] exp_w [DIM];
    int j_s = 0;
    int rdy_mode = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_rdy();
        out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc - j_s) % 3 == 0);
    endtask

    task automatic clear_stats();
        got.delete();
        en_cnt   = 0;
        en_cur   = 0;
        en_max   = 0;
        done_cnt = 0;
        d_cyc    = -1;
    endtask

    task automatic do_job(input int gap_at, input int gap_len, input int mode,
                          input bit st_load, input bit st_drain);
        int b;
        clear_stats();
        rdy_mode = mode;
        j_s = cyc;
        start = 1'b1;
        drv_rdy();
        tick();
        start = 1'b0;
        for (int i = 0; i < DIM; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    in_valid = 1'b0;
                    drv_rdy();
                    tick();
                end
            end
            in_valid = 1'b1;
            in_data  = job_ops[i];
            start    = st_load && (i == 2);
            drv_rdy();
            tick();
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        start    = 1'b0;
        b = 0;
        while (m_act && b < 200) begin
            start = st_drain && (cyc == m_a + RUN + 3);
            drv_rdy();
            tick();
            b++;
        end
        start = 1'b0;
        chk("job_timeout", {31'b0, m_act}, 0);
        tick();
        tick();
    endtask

    task automatic pin_job(input string nm, input int exp_lat);
        chk({nm, "_hs"}, got.size(), DIM);
        for (int i = 0; i < DIM; i++) begin
            chk({nm, "_word"}, (i < got.size()) ? got[i] : 8'hxx, exp_w[i]);
        end
        chk({nm, "_en_cnt"}, en_cnt, RUN);
        chk({nm, "_en_run"}, en_max, RUN);
        chk({nm, "_done_cnt"}, done_cnt, 1);
        chk({nm, "_done_lat"}, d_cyc - j_s, exp_lat);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #0 rst_n = 1'b0;
        #1;
        chk("reset_outs", {busy, in_ready, arr_en, out_valid, done, arr_in, out_data}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 0);

        job_ops = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        exp_w   = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        do_job(-1, 0, 0, 1'b0, 1'b0);
        pin_job("basic", 40);

        job_ops = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        exp_w   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        do_job(-1, 0, 1, 1'b0, 1'b0);
        pin_job("bkpr", 55);

        job_ops = '{8'hF0, 8'h0F, 8'hC3, 8'h3C, 8'h99, 8'h66, 8'hAA, 8'h55};
        exp_w   = '{8'hF0, 8'h0F, 8'hC3, 8'h3C, 8'h99, 8'h66, 8'hAA, 8'h55};
        do_job(4, 3, 0, 1'b0, 1'b0);
        pin_job("gaps", 43);

        clear_stats();
        rdy_mode = 0;
        j_s = cyc;
        job_ops = '{8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'h7E, 8'h5A, 8'h81};
        start = 1'b1;
        drv_rdy();
        tick();
        start = 1'b0;
        for (int i = 0; i < DIM; i++) begin
            in_valid = 1'b1;
            in_data  = job_ops[i];
            tick();
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (5) tick();
        chk("abort_pre_en", arr_en, 1);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_en", arr_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_arr_in", arr_in, 0);
        repeat (3) tick();
        chk("abort_done", done_cnt, 0);

        job_ops = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        exp_w   = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        do_job(-1, 0, 0, 1'b0, 1'b0);
        pin_job("post_abort", 40);

        job_ops = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1};
        exp_w   = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1};
        do_job(-1, 0, 0, 1'b1, 1'b1);
        pin_job("ign_start", 40);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h3C;
            tick();
        end
        chk("pre_reset_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outs", {busy, in_ready, arr_en, out_valid, done, arr_in, out_data}, 0);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("post_reset_busy", busy, 0);
        chk("post_reset_in_ready", in_ready, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
